// File: rtl/window_v_line_buffer_7x1_fp16.sv
// -----------------------------------------------------------------------------
// window_v_line_buffer_7x1_fp16
//
// Vertical window generator for the 7x1 box convolution stage. It takes a
// raster-order FP16 pixel stream and keeps the previous WINDOW_HEIGHT-1 lines
// in line memories. Once enough lines of the current frame are stored, it
// emits one full column window per accepted pixel. Pixel words are passed
// through bit-exact; no floating-point arithmetic is performed.
//
// Ports
//   clk_i     : clock, all state on the rising edge
//   rst_i     : asynchronous active-low reset
//   data_i    : input pixel (raw FP bits)
//   col_i     : pixel column
//   row_i     : pixel row
//   valid_i   : pixel qualifier (no backpressure)
//   window_o  : column window, [0] = oldest row, [H-1] = current row
//   col_o     : window centre column
//   row_o     : window centre row (row_i - (H-1)/2)
//   valid_o   : single-cycle window qualifier
// -----------------------------------------------------------------------------
module window_v_line_buffer_7x1_fp16 #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_WIDTH  = 1,
    parameter int WINDOW_HEIGHT = 7,
    parameter int IMAGE_WIDTH   = 640,
    localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int LINES  = WINDOW_HEIGHT - 1;
    localparam int ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int CNT_W  = $clog2(WINDOW_HEIGHT);

    localparam logic [15:0]      IMG_W     = 16'(IMAGE_WIDTH);
    localparam logic [15:0]      LAST_COL  = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]      HALF_H    = 16'((WINDOW_HEIGHT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_t;

    // Line memories: lb_mem[0] holds the previous line, lb_mem[LINES-1] the oldest.
    logic [FP_WIDTH_REG-1:0] lb_mem [LINES][IMAGE_WIDTH];

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              lines_q, lines_d;
    window_t                       window_q, window_d;
    logic [15:0]                   col_q, col_d;
    logic [15:0]                   row_q, row_d;
    logic                          valid_q, valid_d;

    logic [ADDR_W-1:0]             addr_s;
    logic                          accept_s;
    logic                          frame_start_s;
    logic                          write_s;
    logic                          emit_s;
    logic [LINES-1:0][FP_WIDTH_REG-1:0] rd_s;

    // Out-of-range columns are dropped entirely, so the address is only used when in range.
    assign addr_s        = col_i[ADDR_W-1:0];
    assign accept_s      = valid_i && (col_i < IMG_W);
    assign frame_start_s = accept_s && (col_i == 16'd0) && (row_i == 16'd0);

    // Read the column of every line memory (old values, before this cycle's write).
    always_comb begin
        for (int k = 0; k < LINES; k++) begin
            rd_s[k] = lb_mem[k][addr_s];
        end
    end

    // Column-wise shift: new pixel enters line 0, every line moves one step older.
    always_ff @(posedge clk_i) begin
        if (write_s) begin
            lb_mem[0][addr_s] <= data_i;
            for (int k = 1; k < LINES; k++) begin
                lb_mem[k][addr_s] <= rd_s[k-1];
            end
        end
    end

    // State and filled-line counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            lines_q <= lines_d;
        end
    end

    // Next-state logic; a frame start overrides every state and restarts the fill.
    always_comb begin
        state_d = state_q;
        lines_d = lines_q;
        if (frame_start_s) begin
            state_d = ST_FILL;
            lines_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FILL: begin
                    if (accept_s && (col_i == LAST_COL)) begin
                        lines_d = lines_q + CNT_W'(1);
                        if (lines_q == LAST_LINE) begin
                            state_d = ST_STREAM;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_STREAM: begin
                    state_d = ST_STREAM;
                end
                default: begin
                    state_d = ST_IDLE;
                    lines_d = '0;
                end
            endcase
        end
    end

    // Output logic: memory write enable, window assembly and hold of the last window.
    always_comb begin
        write_s  = accept_s && (frame_start_s || (state_q != ST_IDLE));
        emit_s   = accept_s && !frame_start_s && (state_q == ST_STREAM);
        window_d = window_q;
        col_d    = col_q;
        row_d    = row_q;
        valid_d  = 1'b0;
        if (emit_s) begin
            window_d[WINDOW_HEIGHT-1][0] = data_i;
            for (int k = 1; k < WINDOW_HEIGHT; k++) begin
                window_d[WINDOW_HEIGHT-1-k][0] = rd_s[k-1];
            end
            col_d   = col_i;
            row_d   = row_i - HALF_H;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            window_q <= '0;
            col_q    <= 16'd0;
            row_q    <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            window_q <= window_d;
            col_q    <= col_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
        end
    end

    assign window_o = window_q;
    assign col_o    = col_q;
    assign row_o    = row_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_window_v_line_buffer_7x1_fp16.sv
module tb_window_v_line_buffer_7x1_fp16;

    localparam int H  = 7;
    localparam int IW = 8;
    localparam int FW = 16;

    logic                        clk = 1'b0;
    logic                        rst_i = 1'b0;
    logic [FW-1:0]               data_i = 16'd0;
    logic [15:0]                 col_i = 16'd0;
    logic [15:0]                 row_i = 16'd0;
    logic                        valid_i = 1'b0;
    logic [H-1:0][0:0][FW-1:0]   window_o;
    logic [15:0]                 col_o;
    logic [15:0]                 row_o;
    logic                        valid_o;

    window_v_line_buffer_7x1_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(1),
        .WINDOW_HEIGHT(H), .IMAGE_WIDTH(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .col_i(col_i),
        .row_i(row_i), .valid_i(valid_i), .window_o(window_o),
        .col_o(col_o), .row_o(row_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [H-1:0][FW-1:0] w;
        logic [15:0]          col;
        logic [15:0]          row;
        int                   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   win_cnt = 0;
    int   phase = 0;
    logic [FW-1:0] last_w0_dut;

    // Reference model: per-column history of the rows written in this frame, newest first.
    int            m_mode;   // 0 idle, 1 filling, 2 streaming
    int            m_lines;
    logic [FW-1:0] hist [IW][H-1];
    logic [H-1:0][FW-1:0] last_w;
    logic [15:0]   last_col;
    logic [15:0]   last_row;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_lines  = 0;
        exp_q.delete();
        last_w   = '0;
        last_col = 16'd0;
        last_row = 16'd0;
    endtask

    task automatic model_step(input int c, input int r, input logic [FW-1:0] d);
        exp_t e;
        bit   fs;
        if (c >= IW) return;
        fs = (c == 0) && (r == 0);
        if (fs) begin
            m_mode  = 1;
            m_lines = 0;
        end
        if (m_mode == 0) return;
        if (m_mode == 2 && !fs) begin
            e.w[H-1] = d;
            for (int k = 1; k < H; k++) e.w[H-1-k] = hist[c][k-1];
            e.col = 16'(c);
            e.row = 16'(r) - 16'd3;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        for (int j = H - 2; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = d;
        if (m_mode == 1 && c == IW - 1) begin
            m_lines++;
            if (m_lines == H - 1) m_mode = 2;
        end
    endtask

    task automatic pix(input int c, input int r, input bit v, input logic [15:0] key);
        @(negedge clk);
        col_i   = 16'(c);
        row_i   = 16'(r);
        data_i  = {8'(r), 8'(c)} ^ key;
        valid_i = v;
        if (v) model_step(c, r, data_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            col_i   = 16'($urandom);
            row_i   = 16'($urandom);
            data_i  = 16'($urandom);
        end
    endtask

    task automatic send_row_part(input int r, input int c0, input int c1,
                                 input logic [15:0] key, input bit gaps, input bit bad);
        for (int c = c0; c <= c1; c++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            pix(c, r, 1'b1, key);
            if (bad && c == 3) pix(IW + $urandom_range(0, 3), r, 1'b1, key);
        end
    endtask

    task automatic send_rows(input int r0, input int r1, input logic [15:0] key,
                             input bit gaps, input bit bad);
        for (int r = r0; r <= r1; r++) send_row_part(r, 0, IW - 1, key, gaps, bad);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid", 128'(valid_o), 128'(1'b0));
        check("rst_window", 128'(window_o), 128'd0);
        check("rst_col", 128'(col_o), 128'd0);
        check("rst_row", 128'(row_o), 128'd0);
        model_reset();
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    // Monitor: pops an expectation for every window, otherwise checks outputs hold.
    always @(negedge clk) begin
        if (rst_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_window: got valid_o=1 col=%0d row=%0d, expected no window", col_o, row_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("window", 128'(window_o), 128'(e.w));
                    check("col", 128'(col_o), 128'(e.col));
                    check("row", 128'(row_o), 128'(e.row));
                    check("latency", 128'(cyc), 128'(e.cyc + 1));
                    if (phase == 1 && win_cnt == 0) begin
                        for (int k = 0; k < H; k++)
                            check("first_window", 128'(window_o[k][0]), 128'({8'(k), 8'd0}));
                        check("first_row", 128'(row_o), 128'd3);
                        check("first_col", 128'(col_o), 128'd0);
                    end
                    last_w      = e.w;
                    last_col    = e.col;
                    last_row    = e.row;
                    last_w0_dut = window_o[0][0];
                    win_cnt++;
                end
            end else begin
                check("hold_window", 128'(window_o), 128'(last_w));
                check("hold_col", 128'(col_o), 128'(last_col));
                check("hold_row", 128'(row_o), 128'(last_row));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] key_a;
        logic [15:0] key_b;
        model_reset();
        #1;
        check("init_valid", 128'(valid_o), 128'(1'b0));
        check("init_window", 128'(window_o), 128'd0);
        check("init_col", 128'(col_o), 128'd0);
        check("init_row", 128'(row_o), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;

        // Directed frame, continuous valid.
        phase = 1; win_cnt = 0;
        send_rows(0, 9, 16'h0000, 1'b0, 1'b0);
        idle(3);
        check("frame1_count", 128'(win_cnt), 128'd32);
        check("frame1_last_w0", 128'(last_w0_dut), 128'h0307);

        // Same frame with random gaps.
        phase = 2; win_cnt = 0;
        send_rows(0, 9, 16'h0000, 1'b1, 1'b0);
        idle(3);
        check("gap_count", 128'(win_cnt), 128'd32);

        // Out-of-range columns injected mid-row.
        phase = 3; win_cnt = 0;
        key_a = 16'($urandom);
        send_rows(0, 9, key_a, 1'b0, 1'b1);
        idle(2);
        check("badcol_count", 128'(win_cnt), 128'd32);

        // Reset in the middle of row 7, stale pixels, then a fresh frame.
        phase = 4;
        key_a = 16'($urandom);
        key_b = 16'($urandom);
        send_rows(0, 6, key_a, 1'b0, 1'b0);
        send_row_part(7, 0, 3, key_a, 1'b0, 1'b0);
        async_reset();
        win_cnt = 0;
        send_row_part(7, 4, 7, key_a, 1'b0, 1'b0);
        send_rows(8, 9, key_a, 1'b0, 1'b0);
        idle(2);
        check("ignored_after_reset", 128'(win_cnt), 128'd0);
        send_rows(0, 9, key_b, 1'b1, 1'b0);
        idle(2);
        check("post_reset_count", 128'(win_cnt), 128'd32);

        // Back-to-back frames with different data.
        phase = 5; win_cnt = 0;
        key_a = 16'($urandom);
        key_b = 16'($urandom);
        send_rows(0, 9, key_a, 1'b0, 1'b0);
        send_rows(0, 9, key_b, 1'b0, 1'b0);
        idle(2);
        check("b2b_count", 128'(win_cnt), 128'd64);

        // Restart during row 4 of the fill.
        phase = 6; win_cnt = 0;
        key_a = 16'($urandom);
        key_b = 16'($urandom);
        send_rows(0, 3, key_a, 1'b0, 1'b0);
        send_row_part(4, 0, 4, key_a, 1'b0, 1'b0);
        send_rows(0, 9, key_b, 1'b1, 1'b0);
        idle(5);
        check("restart_count", 128'(win_cnt), 128'd32);
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
